// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : 640x480 @ 60 Hz timing constants and the shared coordinate type.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

   localparam int unsigned VGA_H_VISIBLE = 640;
   localparam int unsigned VGA_H_FRONT   = 16;
   localparam int unsigned VGA_H_SYNC    = 96;
   localparam int unsigned VGA_H_BACK    = 48;
   localparam int unsigned VGA_H_TOTAL   = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

   localparam int unsigned VGA_V_VISIBLE = 480;
   localparam int unsigned VGA_V_FRONT   = 10;
   localparam int unsigned VGA_V_SYNC    = 2;
   localparam int unsigned VGA_V_BACK    = 33;
   localparam int unsigned VGA_V_TOTAL   = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

   localparam int unsigned VGA_CNT_W     = 10;

   typedef logic [VGA_CNT_W-1:0] coord_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for signals asynchronous to clk.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster counters and registered sync/visible/frame decode.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
   parameter int unsigned H_FRONT   = VGA_H_FRONT,
   parameter int unsigned H_SYNC    = VGA_H_SYNC,
   parameter int unsigned H_BACK    = VGA_H_BACK,
   parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
   parameter int unsigned V_FRONT   = VGA_V_FRONT,
   parameter int unsigned V_SYNC    = VGA_V_SYNC,
   parameter int unsigned V_BACK    = VGA_V_BACK
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pll_locked,
   output logic                 hsync_n,
   output logic                 vsync_n,
   output logic                 video_on,
   output logic [VGA_CNT_W-1:0] pixel_col,
   output logic [VGA_CNT_W-1:0] pixel_row,
   output logic                 frame_start
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned CNT_MAX = 1 << VGA_CNT_W;

   if ((H_TOTAL > CNT_MAX) || (V_TOTAL > CNT_MAX)) begin : g_total_too_large
      $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the counter range");
   end

   localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
   localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
   localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
   localparam coord_t H_SYNC_BEG = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t H_SYNC_END = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t V_SYNC_BEG = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t V_SYNC_END = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

   logic   lock_s;
   logic   run;
   logic   h_wrap;
   logic   v_wrap;
   coord_t h_cnt;
   coord_t v_cnt;
   logic   hsync_n_d;
   logic   vsync_n_d;
   logic   video_on_d;
   logic   frame_start_d;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   assign run    = lock_s & ~rst;
   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   // Losing lock aborts the frame; counting resumes from (0,0).
   always_ff @(posedge clk) begin
      if (!run) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         h_cnt <= h_wrap ? '0 : h_cnt + coord_t'(1);
         if (h_wrap) begin
            v_cnt <= v_wrap ? '0 : v_cnt + coord_t'(1);
         end
      end
   end

   always_comb begin
      hsync_n_d     = 1'b1;
      vsync_n_d     = 1'b1;
      video_on_d    = 1'b0;
      frame_start_d = 1'b0;
      hsync_n_d     = ~((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
      vsync_n_d     = ~((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
      video_on_d    = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
   end

   // Gating on run keeps the syncs high and the flags low while unlocked.
   always_ff @(posedge clk) begin
      if (!run) begin
         hsync_n     <= 1'b1;
         vsync_n     <= 1'b1;
         video_on    <= 1'b0;
         frame_start <= 1'b0;
         pixel_col   <= '0;
         pixel_row   <= '0;
      end else begin
         hsync_n     <= hsync_n_d;
         vsync_n     <= vsync_n_d;
         video_on    <= video_on_d;
         frame_start <= frame_start_d;
         pixel_col   <= h_cnt;
         pixel_row   <= v_cnt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Directed bench: full-size timing plus a reduced-timing instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

   // Reduced raster: 35 clocks/line, 21 lines/frame, 735 clocks/frame.
   localparam int unsigned LIMIT = 2000;
   localparam logic [23:0] IDLE  = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};
   localparam logic [23:0] FS0   = {1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_locked;

   logic       hsync_n, vsync_n, video_on, frame_start;
   logic [9:0] pixel_col, pixel_row;
   logic       hsync_n_s, vsync_n_s, video_on_s, frame_start_s;
   logic [9:0] pixel_col_s, pixel_row_s;
   logic [23:0] obs, obs_s;

   int tests_run    = 0;
   int tests_failed = 0;

   assign obs   = {hsync_n, vsync_n, video_on, frame_start, pixel_col, pixel_row};
   assign obs_s = {hsync_n_s, vsync_n_s, video_on_s, frame_start_s, pixel_col_s, pixel_row_s};

   always #20 clk = ~clk;

   vga_sync_gen dut (
      .clk         (clk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .hsync_n     (hsync_n),
      .vsync_n     (vsync_n),
      .video_on    (video_on),
      .pixel_col   (pixel_col),
      .pixel_row   (pixel_row),
      .frame_start (frame_start)
   );

   vga_sync_gen #(
      .H_VISIBLE (20), .H_FRONT (4), .H_SYNC (6), .H_BACK (5),
      .V_VISIBLE (12), .V_FRONT (3), .V_SYNC (2), .V_BACK (4)
   ) dut_s (
      .clk         (clk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .hsync_n     (hsync_n_s),
      .vsync_n     (vsync_n_s),
      .video_on    (video_on_s),
      .pixel_col   (pixel_col_s),
      .pixel_row   (pixel_row_s),
      .frame_start (frame_start_s)
   );

   task automatic test_reset();
      rst        = 1'b1;
      pll_locked = 1'b1;
      repeat (5) @(negedge clk);
      tests_run++;
      if (obs !== IDLE) begin tests_failed++; $display("FAIL reset_hold: got %h expected %h", obs, IDLE); end
      tests_run++;
      if (obs_s !== IDLE) begin tests_failed++; $display("FAIL reset_hold_s: got %h expected %h", obs_s, IDLE); end
      rst = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clk);
         tests_run++;
         if (obs !== IDLE) begin tests_failed++; $display("FAIL reset_latency%0d: got %h expected %h", k, obs, IDLE); end
      end
      @(negedge clk);
      tests_run++;
      if (obs !== FS0) begin tests_failed++; $display("FAIL reset_first_fs: got %h expected %h", obs, FS0); end
      tests_run++;
      if (obs_s !== FS0) begin tests_failed++; $display("FAIL reset_first_fs_s: got %h expected %h", obs_s, FS0); end
   endtask

   // Starts on the frame_start sample left by test_reset.
   task automatic test_line();
      int von = 0, hlow = 0, hfall = -1, hrise = -1, colerr = 0, fs_cnt = 0;
      for (int i = 0; i < 800; i++) begin
         if (i != 0) @(negedge clk);
         if (video_on) von++;
         if (frame_start) fs_cnt++;
         if (!hsync_n) begin
            hlow++;
            if (hfall < 0) hfall = int'(pixel_col);
         end else if (hlow > 0 && hrise < 0) begin
            hrise = int'(pixel_col);
         end
         if (int'(pixel_col) != i || pixel_row != 10'd0 || vsync_n !== 1'b1) colerr++;
      end
      tests_run++;
      if (von != 640) begin tests_failed++; $display("FAIL line_video_on: got %0d expected 640", von); end
      tests_run++;
      if (hlow != 96) begin tests_failed++; $display("FAIL line_hsync_width: got %0d expected 96", hlow); end
      tests_run++;
      if (hfall != 656) begin tests_failed++; $display("FAIL line_hsync_fall: got %0d expected 656", hfall); end
      tests_run++;
      if (hrise != 752) begin tests_failed++; $display("FAIL line_hsync_rise: got %0d expected 752", hrise); end
      tests_run++;
      if (colerr != 0) begin tests_failed++; $display("FAIL line_col_seq: got %0d bad samples expected 0", colerr); end
      tests_run++;
      if (fs_cnt != 1) begin tests_failed++; $display("FAIL line_fs_once: got %0d expected 1", fs_cnt); end
      @(negedge clk);
      tests_run++;
      if ({frame_start, pixel_col, pixel_row} !== {1'b0, 10'd0, 10'd1}) begin
         tests_failed++;
         $display("FAIL line_period: got fs=%b col=%0d row=%0d expected fs=0 col=0 row=1", frame_start, pixel_col, pixel_row);
      end
   endtask

   task automatic test_frame();
      int n = 0, vlow = 0, vbad = 0, vid = 0, maxr = 0, maxc = 0;
      while (!frame_start_s && n < LIMIT) begin @(negedge clk); n++; end
      tests_run++;
      if (n >= LIMIT) begin tests_failed++; $display("FAIL frame_wait: timeout after %0d clocks", n); end
      n = 0;
      do begin
         if (!vsync_n_s) vlow++;
         if ((!vsync_n_s) != (pixel_row_s == 10'd15 || pixel_row_s == 10'd16)) vbad++;
         if (video_on_s) vid++;
         if (int'(pixel_row_s) > maxr) maxr = int'(pixel_row_s);
         if (int'(pixel_col_s) > maxc) maxc = int'(pixel_col_s);
         @(negedge clk);
         n++;
      end while (!frame_start_s && n < LIMIT);
      tests_run++;
      if (n != 735) begin tests_failed++; $display("FAIL frame_period: got %0d expected 735", n); end
      tests_run++;
      if (vlow != 70) begin tests_failed++; $display("FAIL frame_vsync_width: got %0d expected 70", vlow); end
      tests_run++;
      if (vbad != 0) begin tests_failed++; $display("FAIL frame_vsync_rows: got %0d bad samples expected 0", vbad); end
      tests_run++;
      if (vid != 240) begin tests_failed++; $display("FAIL frame_visible: got %0d expected 240", vid); end
      tests_run++;
      if (maxr != 20 || maxc != 34) begin
         tests_failed++;
         $display("FAIL frame_max_coord: got row=%0d col=%0d expected row=20 col=34", maxr, maxc);
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      while (!(pixel_row_s == 10'd20 && pixel_col_s == 10'd34) && n < LIMIT) begin @(negedge clk); n++; end
      tests_run++;
      if (n >= LIMIT) begin tests_failed++; $display("FAIL wrap_wait: timeout after %0d clocks", n); end
      @(negedge clk);
      tests_run++;
      if (obs_s !== FS0) begin tests_failed++; $display("FAIL wrap_corner: got %h expected %h", obs_s, FS0); end
   endtask

   task automatic test_lock_loss();
      int n = 0, bad = 0;
      while (!(pixel_row_s == 10'd5 && pixel_col_s == 10'd10) && n < LIMIT) begin @(negedge clk); n++; end
      tests_run++;
      if (n >= LIMIT) begin tests_failed++; $display("FAIL lock_wait: timeout after %0d clocks", n); end
      pll_locked = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (pixel_col_s !== 10'd12) begin tests_failed++; $display("FAIL lock_sync_delay: got col=%0d expected 12", pixel_col_s); end
      @(negedge clk);
      tests_run++;
      if (obs !== IDLE || obs_s !== IDLE) begin
         tests_failed++;
         $display("FAIL lock_loss_idle: got %h/%h expected %h", obs, obs_s, IDLE);
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (obs !== IDLE || obs_s !== IDLE) bad++;
      end
      pll_locked = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (obs !== IDLE || obs_s !== IDLE) bad++;
      end
      tests_run++;
      if (bad != 0) begin tests_failed++; $display("FAIL unlocked_idle: got %0d bad samples expected 0", bad); end
      @(negedge clk);
      tests_run++;
      if (obs !== FS0 || obs_s !== FS0) begin
         tests_failed++;
         $display("FAIL relock_fs: got %h/%h expected %h", obs, obs_s, FS0);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0, bad = 0;
      while (!(pixel_row_s == 10'd16 && pixel_col_s == 10'd5) && n < LIMIT) begin @(negedge clk); n++; end
      tests_run++;
      if (n >= LIMIT || vsync_n_s !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_setup: got vsync_n=%b after %0d clocks expected 0", vsync_n_s, n);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests_run++;
      if (obs_s !== IDLE) begin tests_failed++; $display("FAIL rstmid_vsync_release: got %h expected %h", obs_s, IDLE); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (obs !== IDLE || obs_s !== IDLE) bad++;
      end
      tests_run++;
      if (bad != 0) begin tests_failed++; $display("FAIL rstmid_latency: got %0d bad samples expected 0", bad); end
      @(negedge clk);
      tests_run++;
      if (obs !== FS0 || obs_s !== FS0) begin
         tests_failed++;
         $display("FAIL rstmid_restart: got %h/%h expected %h", obs, obs_s, FS0);
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_frame();
      test_wrap();
      test_lock_loss();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator for the 640x480 @ 60 Hz VGA output.
- Clocked by the 25 MHz pixel clock from the PLL stage. Consumes that stage's lock indication.
- Produces active-low hsync/vsync, the visible-region flag, current pixel row/column and a frame-start pulse.
- Feeds the game's pixel/sprite renderers and the VGA DAC pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk  in  1  25 MHz pixel clock (PLL output clock)
- rst  in  1  synchronous, active-high reset
- pll_locked  in  1  PLL lock flag; asynchronous to clk while the PLL settles
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- video_on  out  1  high while the current pixel is in the visible area
- pixel_col  out  10  column of the current pixel, 0..H_TOTAL-1
- pixel_row  out  10  row of the current pixel, 0..V_TOTAL-1
- frame_start  out  1  one-clock pulse at pixel (0,0)

Behaviour:
- Derived totals: H_TOTAL = sum of the four H_* parameters (800). V_TOTAL = sum of the four V_* parameters (525). Counters are 10 bits; elaboration must fail if either total exceeds 1024.
- Lock synchroniser: pll_locked passes through two flops to form lock_s. Both flops clear on rst.
- Running condition: run = lock_s & ~rst.
- Horizontal counter h_cnt:
  - Increments each clk while run.
  - Wraps from H_TOTAL-1 to 0.
- Vertical counter v_cnt:
  - Increments only on the h_cnt wrap.
  - Wraps from V_TOTAL-1 to 0 on the same clock that h_cnt wraps.
- Counter clear: if rst or ~lock_s, both counters load 0. Lock loss mid-frame therefore aborts the frame. Counting restarts at (0,0) two clocks after pll_locked rises again.
- Outputs are registered, with one clock of latency from the counters. All outputs describe the same (h_cnt, v_cnt) sample.
  - pixel_col = h_cnt; pixel_row = v_cnt.
  - video_on = (h_cnt < H_VISIBLE) & (v_cnt < V_VISIBLE) & lock_s.
  - hsync_n = 0 when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751), else 1.
  - vsync_n = 0 when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491), else 1. Lines 490 and 491 are low in their entirety.
  - frame_start = 1 when h_cnt==0 & v_cnt==0 & lock_s.
- Reset / unlocked output values: hsync_n=1, vsync_n=1, video_on=0, pixel_col=0, pixel_row=0, frame_start=0.
  - The same values hold for every cycle while lock_s is low.
  - Sync outputs must never glitch low while unlocked.
- Frame length: exactly 420000 clocks between consecutive frame_start pulses while locked.
- Simultaneous events:
  - rst has priority over lock.
  - The h wrap and v wrap on the same clock produce a single transition to (0,0); frame_start is asserted for that sample.

Decomposition:
- Shared package vga_pkg:
  - 640x480 timing constants (visible, porch and sync widths, H_TOTAL, V_TOTAL).
  - Counter width constant (10).
  - Coordinate type for row/col.
  - Renderers import the same package.
- Sub-module sync_2ff: the two-flop synchroniser, reused for the button and keyboard inputs elsewhere.
- The counters and output decode stay in vga_sync_gen.

Test Plan:
- Reset while pll_locked=1: hold rst 5 clocks, release. Outputs stay at reset values through the sync latency. frame_start pulses exactly once, 3 clocks after rst falls, with pixel_col=0 and pixel_row=0.
- Line timing: from frame_start, count clocks.
  - video_on high for 640 clocks, low for 160.
  - hsync_n falls at pixel_col=656 and rises at 752.
  - Line period is 800 clocks.
- Frame timing:
  - vsync_n is low only for pixel_row 490 and 491, i.e. 1600 clocks.
  - Next frame_start arrives exactly 420000 clocks after the previous one.
  - pixel_row never exceeds 524; pixel_col never exceeds 799.
- Wrap corner: at pixel_col=799, pixel_row=524, the next sample is (0,0) with frame_start=1, and pixel_row does not pass through 525.
- Lock loss mid-frame: drop pll_locked at row 200, col 300.
  - Within 3 clocks, outputs go to idle values (hsync_n=vsync_n=1, video_on=0, row=col=0).
  - Re-assert pll_locked; frame_start fires 3 clocks later.
- Reset mid-frame: assert rst for 1 clock at row 491 while vsync_n=0. The next output sample has vsync_n=1 and counters restart from (0,0).
